// File: rtl/matrix_host_port.sv
// matrix_host_port: host front end to the matrix coprocessor shared RAM.
// Optional build macro HOST_TIMEOUT_EN adds a WAIT_DONE watchdog and err flag.
module matrix_host_port #(
    parameter int MEM_RD_LAT     = 1,
    parameter int RESULT_BASE    = 25,
    parameter int OVF_ADDR       = 50,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [1:0]  size,
    output logic        busy,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic [6:0]  mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_we,
    input  logic [15:0] mem_q,
    output logic        cop_start,
    input  logic        cop_done,
    output logic        err
);

    localparam logic [6:0] RES_A = 7'(RESULT_BASE);
    localparam logic [6:0] OVF_A = 7'(OVF_ADDR);
    localparam logic [1:0] LAT_A = 2'(MEM_RD_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_EMIT
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [4:0]  k_q, k_d;
    logic [2:0]  lr_q, lr_d;
    logic [2:0]  lc_q, lc_d;
    logic [2:0]  rr_q, rr_d;
    logic [2:0]  rc_q, rc_d;
    logic        ovf_q, ovf_d;
    logic [1:0]  lat_q, lat_d;
    logic [6:0]  mem_addr_q, mem_addr_d;
    logic [15:0] mem_data_q, mem_data_d;
    logic        mem_we_q, mem_we_d;
    logic        cop_start_q, cop_start_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_last_q, out_last_d;

    logic [2:0]  n;
    logic        load_in;
    logic [6:0]  rd_slot;
    logic        unused_ok;

    // Active edge length N and slot classification for the load walk.
    assign n       = {1'b0, size_q} + 3'd2;
    assign load_in = (lr_q < n) && (lc_q < n);
    assign rd_slot = 7'(rr_q) * 7'd5 + 7'(rc_q);

`ifdef HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
    assign err       = err_q;
    assign unused_ok = ^mem_q[15:8];
`else
    assign err       = 1'b0;
    assign unused_ok = ^{mem_q[15:8], TIMEOUT_CYCLES[0]};
`endif

    assign busy      = (state_q != S_IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_we    = mem_we_q;
    assign cop_start = cop_start_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    // Next-state and registered-output decisions for the whole sequence.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        k_d         = k_q;
        lr_d        = lr_q;
        lc_d        = lc_q;
        rr_d        = rr_q;
        rc_d        = rc_q;
        ovf_d       = ovf_q;
        lat_d       = lat_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_we_d    = 1'b0;
        cop_start_d = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        in_ready    = 1'b0;
`ifdef HOST_TIMEOUT_EN
        wd_d        = wd_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    size_d  = size;
                    k_d     = 5'd0;
                    lr_d    = 3'd0;
                    lc_d    = 3'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = load_in;
                // Out-of-range slots are zero-filled without a handshake.
                if (!load_in || in_valid) begin
                    mem_addr_d = {2'b00, k_q};
                    mem_data_d = load_in ? in_data : 16'h0000;
                    mem_we_d   = 1'b1;
                    k_d        = k_q + 5'd1;
                    if (lc_q == 3'd4) begin
                        lc_d = 3'd0;
                        lr_d = lr_q + 3'd1;
                    end else begin
                        lc_d = lc_q + 3'd1;
                    end
                    if (k_q == 5'd24) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                cop_start_d = 1'b1;
                state_d     = S_WAIT;
`ifdef HOST_TIMEOUT_EN
                wd_d        = '0;
`endif
            end
            S_WAIT: begin
                if (cop_done) begin
                    rr_d    = 3'd0;
                    rc_d    = 3'd0;
                    ovf_d   = 1'b0;
                    state_d = S_RD_ISSUE;
                end
`ifdef HOST_TIMEOUT_EN
                else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + TW'(1);
                end
`endif
            end
            S_RD_ISSUE: begin
                mem_addr_d = ovf_q ? OVF_A : (RES_A + rd_slot);
                lat_d      = 2'd0;
                state_d    = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // One cycle for the address to reach the RAM, then its latency.
                if (lat_q == LAT_A) begin
                    out_data_d  = ovf_q ? {7'b0, mem_q[0]} : mem_q[7:0];
                    out_last_d  = ovf_q;
                    out_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (ovf_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RD_ISSUE;
                        if (rc_q + 3'd1 < n) begin
                            rc_d = rc_q + 3'd1;
                        end else if (rr_q + 3'd1 < n) begin
                            rr_d = rr_q + 3'd1;
                            rc_d = 3'd0;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            size_q      <= 2'd0;
            k_q         <= 5'd0;
            lr_q        <= 3'd0;
            lc_q        <= 3'd0;
            rr_q        <= 3'd0;
            rc_q        <= 3'd0;
            ovf_q       <= 1'b0;
            lat_q       <= 2'd0;
            mem_addr_q  <= 7'd0;
            mem_data_q  <= 16'h0000;
            mem_we_q    <= 1'b0;
            cop_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            k_q         <= k_d;
            lr_q        <= lr_d;
            lc_q        <= lc_d;
            rr_q        <= rr_d;
            rc_q        <= rc_d;
            ovf_q       <= ovf_d;
            lat_q       <= lat_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_we_q    <= mem_we_d;
            cop_start_q <= cop_start_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef HOST_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_host_port.sv
// tb_matrix_host_port: randomized bench with a slot/row-major reference model
// and a behavioural RAM for matrix_host_port.
`timescale 1ns/1ps
module tb_matrix_host_port;

    localparam int LAT = 1;
    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        reset, go, busy, in_valid, in_ready;
    logic [1:0]  size;
    logic [15:0] in_data, mem_data, mem_q;
    logic        out_valid, out_ready, out_last, mem_we;
    logic        cop_start, cop_done, err;
    logic [7:0]  out_data;
    logic [6:0]  mem_addr;

    always #5 clk = ~clk;

    matrix_host_port #(
        .MEM_RD_LAT(LAT), .RESULT_BASE(25), .OVF_ADDR(50), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .size(size), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_we(mem_we), .mem_q(mem_q), .cop_start(cop_start),
        .cop_done(cop_done), .err(err)
    );

    // Behavioural RAM: results area 25..50 comes from res[].
    logic [15:0] ram [0:127];
    logic [15:0] res [0:25];
    logic [15:0] rd0, rd1;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data;
        rd0 <= (mem_addr >= 7'd25 && mem_addr <= 7'd50) ? res[mem_addr - 7'd25] : ram[mem_addr];
        rd1 <= rd0;
    end
    assign mem_q = (LAT == 2) ? rd1 : rd0;

    logic [22:0] wr_q[$];
    int start_cnt, bad_addr, ov_cnt;
    always @(negedge clk) begin
        if (mem_we) wr_q.push_back({mem_addr, mem_data});
        if (cop_start) start_cnt++;
        if (mem_addr > 7'd50) bad_addr++;
        if (out_valid) ov_cnt++;
    end

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] pairs[$];
    logic [7:0]  got[$];
    logic        got_last[$];
    int lat_obs, acc_cnt, start_wr, stall_bad, hung, wait_bad;
    logic busy_after;

    task automatic fill_pairs(input int cnt);
        pairs.delete();
        repeat (cnt) pairs.push_back(16'($urandom));
    endtask

    task automatic fill_res;
        for (int i = 0; i < 26; i++) res[i] = 16'($urandom);
    endtask

    // Slot k holds the pair whose row-major index in the N x N stream is r*N+c.
    function automatic logic [15:0] exp_wr(input logic [1:0] sz, input int k);
        int n = int'(sz) + 2;
        int r = k / 5;
        int c = k % 5;
        if (r >= n || c >= n) return 16'h0000;
        return pairs[r * n + c];
    endfunction

    function automatic int wr_errs(input logic [1:0] sz);
        int e = 0;
        if (wr_q.size() != 25) return 99;
        for (int k = 0; k < 25; k++)
            if (wr_q[k] !== {7'(k), exp_wr(sz, k)}) e++;
        return e;
    endfunction

    function automatic int byte_errs(input logic [1:0] sz);
        int n = int'(sz) + 2;
        int e = 0;
        int i = 0;
        if (got.size() != n * n + 1) return 99;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                if (got[i] !== res[r * 5 + c][7:0] || got_last[i] !== 1'b0) e++;
                i++;
            end
        if (got[i] !== {7'b0, res[25][0]} || got_last[i] !== 1'b1) e++;
        return e;
    endfunction

    // One full operation; rdy_mode 0=random 1=pattern 1,0,0,1 2=always.
    // done_dly < 0 returns right after cop_start is seen.
    task automatic run_op(input logic [1:0] sz, input int gap, input int rdy_mode,
                          input int done_dly, input bit done_lvl, input bit glitch,
                          input bit extra, input bit noise);
        int idx, cyc, pat, nb;
        bit stalled, fin;
        logic [8:0] held;
        logic [3:0] pb;
        pb = 4'b1001;
        wr_q.delete(); got.delete(); got_last.delete();
        start_cnt = 0; acc_cnt = 0; hung = 0; stall_bad = 0;
        lat_obs = -1; start_wr = -1; wait_bad = 0; held = '0;
        @(negedge clk); go = 1; size = sz;
        @(negedge clk); go = 0; size = 2'($urandom);
        idx = 0; cyc = 0;
        while (!cop_start && cyc < 300) begin
            if (glitch && cyc == 4) begin go = 1; size = ~sz; end else go = 0;
            cop_done = noise && ($urandom_range(3) == 0);
            if ((idx < pairs.size() || extra) && $urandom_range(99) >= gap) begin
                in_valid = 1;
                in_data = (idx < pairs.size()) ? pairs[idx] : 16'hDEAD;
            end else begin
                in_valid = 0;
            end
            if (in_valid && in_ready) begin idx++; acc_cnt++; end
            @(negedge clk); cyc++;
        end
        in_valid = 0; go = 0; cop_done = 0;
        if (!cop_start) begin hung = 1; return; end
        start_wr = wr_q.size();
        if (done_dly < 0) return;
        repeat (done_dly) begin
            @(negedge clk);
            if (!busy || out_valid) wait_bad++;
        end
        cop_done = 1;
        @(negedge clk);
        if (!done_lvl) cop_done = 0;
        lat_obs = 0;
        while (!out_valid && lat_obs < 50) begin @(negedge clk); lat_obs++; end
        cop_done = 0;
        if (!out_valid) begin hung = 1; return; end
        cyc = 0; pat = 0; nb = 0; stalled = 0; fin = 0;
        while (!fin && cyc < 400) begin
            go = 0;
            if (out_valid) begin
                if (stalled && {out_last, out_data} !== held) stall_bad++;
                if (glitch && nb == 1) go = 1;
                if (rdy_mode == 1) out_ready = pb[3 - (pat % 4)];
                else if (rdy_mode == 2) out_ready = 1;
                else out_ready = ($urandom_range(2) != 0);
                pat++;
                if (out_ready) begin
                    got.push_back(out_data); got_last.push_back(out_last);
                    stalled = 0; nb++;
                    if (out_last) fin = 1;
                end else begin
                    stalled = 1; held = {out_last, out_data};
                end
            end else begin
                out_ready = 1'($urandom_range(1));
            end
            @(negedge clk); cyc++;
        end
        go = 0; out_ready = 0;
        if (!fin) hung = 1;
        busy_after = busy;
    endtask

    task automatic test_reset;
        reset = 1; go = 1; in_valid = 1; in_data = 16'hFFFF; out_ready = 1; cop_done = 1;
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b want 0", busy); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
        n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data got %h want 00", out_data); end
        n_chk++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last got %0b want 0", out_last); end
        n_chk++; if (mem_addr !== 7'd0) begin n_fail++; $display("FAIL rst_mem_addr got %0d want 0", mem_addr); end
        n_chk++; if (mem_data !== 16'h0) begin n_fail++; $display("FAIL rst_mem_data got %h want 0", mem_data); end
        n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %0b want 0", mem_we); end
        n_chk++; if (cop_start !== 1'b0) begin n_fail++; $display("FAIL rst_cop_start got %0b want 0", cop_start); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %0b want 0", err); end
        reset = 0; go = 0; in_valid = 0; out_ready = 0; cop_done = 0;
        @(negedge clk);
    endtask

    task automatic test_load_fixed;
        pairs.delete();
        pairs.push_back(16'h0801); pairs.push_back(16'h0E20);
        pairs.push_back(16'h4C05); pairs.push_back(16'h0112);
        fill_res();
        run_op(2'b00, 0, 2, 2, 0, 0, 0, 0);
        n_chk++; if (hung !== 0) begin n_fail++; $display("FAIL load_hung got %0d want 0", hung); end
        n_chk++; if (wr_errs(2'b00) !== 0) begin n_fail++; $display("FAIL load_writes bad %0d want 0 (n=%0d)", wr_errs(2'b00), wr_q.size()); end
        n_chk++; if (wr_q.size() > 5 && wr_q[5] !== {7'd5, 16'h4C05}) begin n_fail++; $display("FAIL load_slot5 got %h want %h", wr_q[5], {7'd5, 16'h4C05}); end
        n_chk++; if (start_wr !== 25) begin n_fail++; $display("FAIL load_start_after got %0d want 25", start_wr); end
        n_chk++; if (start_cnt !== 1) begin n_fail++; $display("FAIL load_start_pulses got %0d want 1", start_cnt); end
        n_chk++; if (acc_cnt !== 4) begin n_fail++; $display("FAIL load_accepts got %0d want 4", acc_cnt); end
    endtask

    task automatic test_read_full;
        fill_pairs(25);
        for (int i = 0; i < 25; i++) res[i] = 16'(i);
        res[25] = 16'h0001;
        run_op(2'b11, 20, 2, 3, 0, 0, 0, 0);
        n_chk++; if (hung !== 0) begin n_fail++; $display("FAIL full_hung got %0d want 0", hung); end
        n_chk++; if (wr_errs(2'b11) !== 0) begin n_fail++; $display("FAIL full_writes bad %0d want 0", wr_errs(2'b11)); end
        n_chk++; if (byte_errs(2'b11) !== 0) begin n_fail++; $display("FAIL full_bytes bad %0d want 0 (n=%0d)", byte_errs(2'b11), got.size()); end
        n_chk++; if (lat_obs !== LAT + 2) begin n_fail++; $display("FAIL full_latency got %0d want %0d", lat_obs, LAT + 2); end
        n_chk++; if (got.size() == 26 && got[25] !== 8'h01) begin n_fail++; $display("FAIL full_ovf_byte got %h want 01", got[25]); end
        n_chk++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL full_idle got %0b want 0", busy_after); end
    endtask

    task automatic test_stall;
        fill_pairs(4);
        fill_res();
        res[0] = 16'h0011; res[1] = 16'h0022; res[5] = 16'h0033; res[6] = 16'h0044;
        res[25] = 16'h0000;
        run_op(2'b00, 0, 1, 0, 1, 0, 0, 0);
        n_chk++; if (hung !== 0) begin n_fail++; $display("FAIL stall_hung got %0d want 0", hung); end
        n_chk++; if (byte_errs(2'b00) !== 0) begin n_fail++; $display("FAIL stall_bytes bad %0d want 0 (n=%0d)", byte_errs(2'b00), got.size()); end
        n_chk++; if (stall_bad !== 0) begin n_fail++; $display("FAIL stall_stable got %0d changes want 0", stall_bad); end
        n_chk++; if (got.size() == 5 && got[3] !== 8'h44) begin n_fail++; $display("FAIL stall_byte3 got %h want 44", got[3]); end
    endtask

    task automatic test_ignore;
        fill_pairs(9);
        fill_res();
        run_op(2'b01, 10, 0, 1, 0, 1, 1, 1);
        n_chk++; if (hung !== 0) begin n_fail++; $display("FAIL ign_hung got %0d want 0", hung); end
        n_chk++; if (acc_cnt !== 9) begin n_fail++; $display("FAIL ign_accepts got %0d want 9", acc_cnt); end
        n_chk++; if (wr_errs(2'b01) !== 0) begin n_fail++; $display("FAIL ign_writes bad %0d want 0", wr_errs(2'b01)); end
        n_chk++; if (byte_errs(2'b01) !== 0) begin n_fail++; $display("FAIL ign_bytes bad %0d want 0 (n=%0d)", byte_errs(2'b01), got.size()); end
        n_chk++; if (start_cnt !== 1) begin n_fail++; $display("FAIL ign_start_pulses got %0d want 1", start_cnt); end
    endtask

    task automatic test_reset_midop;
        int acc, cyc, nw;
        fill_pairs(4);
        @(negedge clk); go = 1; size = 2'b00;
        @(negedge clk); go = 0;
        acc = 0; cyc = 0;
        while (acc < 3 && cyc < 100) begin
            in_valid = 1; in_data = pairs[acc];
            if (in_ready) acc++;
            @(negedge clk); cyc++;
        end
        n_chk++; if (acc !== 3) begin n_fail++; $display("FAIL mid_accepts got %0d want 3", acc); end
        in_data = pairs[3];
        reset = 1;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %0b want 0", busy); end
        n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_mem_we got %0b want 0", mem_we); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready got %0b want 0", in_ready); end
        reset = 0;
        nw = wr_q.size();
        repeat (4) @(negedge clk);
        n_chk++; if (wr_q.size() !== nw) begin n_fail++; $display("FAIL mid_no_writes got %0d want %0d", wr_q.size(), nw); end
        in_valid = 0;
        fill_pairs(9);
        fill_res();
        run_op(2'b01, 30, 0, 2, 0, 0, 0, 0);
        n_chk++; if (wr_errs(2'b01) !== 0) begin n_fail++; $display("FAIL mid_reload bad %0d want 0", wr_errs(2'b01)); end
        n_chk++; if (byte_errs(2'b01) !== 0) begin n_fail++; $display("FAIL mid_bytes bad %0d want 0", byte_errs(2'b01)); end
    endtask

    task automatic test_random;
        logic [1:0] sz;
        for (int t = 0; t < 6; t++) begin
            sz = 2'($urandom);
            fill_pairs((int'(sz) + 2) * (int'(sz) + 2));
            fill_res();
            run_op(sz, $urandom_range(60), 0, $urandom_range(8), 1'($urandom_range(1)),
                   0, 0, 1'($urandom_range(1)));
            n_chk++; if (hung !== 0) begin n_fail++; $display("FAIL rnd%0d_hung got %0d want 0", t, hung); end
            n_chk++; if (wr_errs(sz) !== 0) begin n_fail++; $display("FAIL rnd%0d_writes bad %0d want 0", t, wr_errs(sz)); end
            n_chk++; if (byte_errs(sz) !== 0) begin n_fail++; $display("FAIL rnd%0d_bytes bad %0d want 0", t, byte_errs(sz)); end
            n_chk++; if (lat_obs !== LAT + 2) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", t, lat_obs, LAT + 2); end
        end
    endtask

`ifdef HOST_TIMEOUT_EN
    task automatic test_timeout;
        int wcyc, ov0;
        fill_pairs(16);
        run_op(2'b10, 0, 2, -1, 0, 0, 0, 0);
        ov0 = ov_cnt;
        wcyc = 0;
        while (busy && wcyc < 100) begin @(negedge clk); wcyc++; end
        n_chk++; if (wcyc !== TMO) begin n_fail++; $display("FAIL tmo_cycles got %0d want %0d", wcyc, TMO); end
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %0b want 1", err); end
        n_chk++; if (ov_cnt !== ov0) begin n_fail++; $display("FAIL tmo_no_output got %0d want %0d", ov_cnt, ov0); end
        fill_pairs(4);
        fill_res();
        run_op(2'b00, 0, 2, 2, 0, 0, 0, 0);
        n_chk++; if (byte_errs(2'b00) !== 0) begin n_fail++; $display("FAIL tmo_after_bytes bad %0d want 0", byte_errs(2'b00)); end
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky got %0b want 1", err); end
    endtask
`else
    task automatic test_wait_hold;
        fill_pairs(9);
        fill_res();
        run_op(2'b01, 0, 2, 40, 0, 0, 0, 0);
        n_chk++; if (wait_bad !== 0) begin n_fail++; $display("FAIL hold_wait got %0d bad cycles want 0", wait_bad); end
        n_chk++; if (byte_errs(2'b01) !== 0) begin n_fail++; $display("FAIL hold_bytes bad %0d want 0", byte_errs(2'b01)); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL hold_err got %0b want 0", err); end
    endtask
`endif

    task automatic test_bounds;
        n_chk++; if (bad_addr !== 0) begin n_fail++; $display("FAIL addr_range got %0d cycles above 50 want 0", bad_addr); end
    endtask

    initial begin
        reset = 1; go = 0; size = 0; in_valid = 0; in_data = 0;
        out_ready = 0; cop_done = 0;
        start_cnt = 0; bad_addr = 0; ov_cnt = 0; busy_after = 0;
        test_reset();
        test_load_fixed();
        test_read_full();
        test_stall();
        test_ignore();
        test_reset_midop();
        test_random();
`ifdef HOST_TIMEOUT_EN
        test_timeout();
`else
        test_wait_hold();
`endif
        test_bounds();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_host_port.md
Name: matrix_host_port

Overview:
Host-side front end to the matrix coprocessor's shared operand/result memory.
- Accepts operand element pairs {b,a} on a valid/ready input stream and packs them into memory words 0..24 in row-major 5x5 layout, zero-filling slots outside the active N×N.
- Pulses the coprocessor start, then waits for done.
- Reads result words 25..49 plus the overflow word 50 and streams them out as bytes on a valid/ready output stream.

Parameters:
- MEM_RD_LAT, 1, RAM read latency in cycles; must be 1 or 2.
- RESULT_BASE, 25, address of the first result word.
- OVF_ADDR, 50, address of the overflow word.
- TIMEOUT_CYCLES, 1000000, watchdog limit (only with HOST_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- go  in  1  start pulse; sampled only in IDLE
- size  in  2  00=2x2, 01=3x3, 10=4x4, 11=5x5; latched on accepted go
- busy  out  1  high in every state except IDLE
- in_valid  in  1  input pair valid
- in_ready  out  1  input pair accepted when in_valid & in_ready
- in_data  in  16  {b[7:0], a[7:0]}
- out_valid  out  1  output byte valid
- out_ready  in  1  sink ready
- out_data  out  8  result byte, or {7'b0, ovf}
- out_last  out  1  high with the overflow byte
- mem_addr  out  7  RAM address
- mem_data  out  16  RAM write data
- mem_we  out  1  RAM write enable
- mem_q  in  16  RAM read data
- cop_start  out  1  one-cycle start pulse to coprocessor
- cop_done  in  1  coprocessor finished; level or pulse
- err  out  1  sticky timeout flag (0 when HOST_TIMEOUT_EN is absent)

Behaviour:
Reset (clk edge with reset=1) returns every output to 0 and the state to IDLE. This includes busy, in_ready, out_valid, out_data, out_last, mem_*, cop_start and err. Reset takes effect mid-operation in any state, with no further memory writes.

Slot mapping: slot k = r*5+c, k in 0..24. A slot is in range iff r<N and c<N, where N = size+2.

States:
- IDLE: go=1 latches size, sets k=0 → LOAD.
- LOAD, in-range slot: in_ready=1. On handshake, register mem_addr=k, mem_data=in_data, mem_we=1; k++.
- LOAD, out-of-range slot: in_ready=0. Register a write of 0 to k; k++ with no input consumed.
- LOAD exit: after k=24 is written → START. Throughput is one slot per cycle. in_ready is 0 in all other states.
- START: mem_we=0; cop_start=1 for exactly one cycle → WAIT_DONE.
- WAIT_DONE: cop_done is ignored in all states except this one. When cop_done=1, set j=0 → RD_ISSUE.
- RD_ISSUE: mem_addr = RESULT_BASE + j for in-range result slots, skipping out-of-range j; after the last in-range j, mem_addr = OVF_ADDR.
- RD_WAIT: hold for MEM_RD_LAT cycles, then capture out_data = mem_q[7:0], or {7'b0, mem_q[0]} for OVF_ADDR → EMIT.
- Read latency: out_valid first rises MEM_RD_LAT+2 cycles after cop_done is sampled.
- EMIT: out_valid=1, with out_data/out_last stable until out_ready=1. On handshake, the overflow byte goes to IDLE; any other byte advances j and goes to RD_ISSUE.

Output counts:
- N*N+1 bytes per operation.
- out_last=1 only on the final (overflow) byte.

Other rules:
- go while busy is ignored.
- mem_we is asserted only in LOAD.
- The block never reads or writes addresses 51..127.

Optional Feature:
HOST_TIMEOUT_EN:
- Defined: a counter runs in WAIT_DONE. If it reaches TIMEOUT_CYCLES without cop_done, the block sets err=1 and returns to IDLE with no output bytes. err clears only on reset; a later go still operates normally.
- Undefined: WAIT_DONE waits indefinitely, err is tied to 0, and no counter logic is present.

Test Plan:
- size=00, pairs 0x0801, 0x0E20, 0x4C05, 0x0112 → writes addr 0=0x0801, 1=0x0E20, 5=0x4C05, 6=0x0112; all other addresses 0..24 written as 0x0000; exactly 25 writes; single cop_start pulse after the write to addr 24.
- size=11, RAM preloaded 25..49 = 0x0000..0x0018 and 50=0x0001, cop_done pulse, out_ready=1 → 26 bytes 0x00..0x18 then 0x01 with out_last; first out_valid MEM_RD_LAT+2 cycles after done.
- size=00, result words 25=0x0011, 26=0x0022, 30=0x0033, 31=0x0044, 50=0x0000; out_ready toggling 1,0,0,1 → bytes 0x11, 0x22, 0x33, 0x44, 0x00 in order, out_data stable while stalled, no duplicates, last byte flagged.
- go pulsed during LOAD and during EMIT → ignored; size change mid-op has no effect; in_valid held high after 9 pairs at size=01 → no extra accepts.
- reset asserted after the 3rd accepted pair → next cycle busy=0, mem_we=0, in_ready=0; a new go/size=01 then loads 9 pairs from slot 0.
- HOST_TIMEOUT_EN with TIMEOUT_CYCLES=20, cop_done held 0 → err=1, IDLE after 20 WAIT_DONE cycles, out_valid never asserted.
